layer_compositor: RTL

Parametrised frame sequencer and pixel compositor for the VGA view path. It enables up to NUM_LAYERS drawing engines (background, items, hook, score/time and so on) one at a time, in fixed index order. Each layer's pixel stream is multiplexed onto a single registered write port into the frame buffer, with per-layer colour-key transparency, layer skipping, a per-layer watchdog and a continuous-refresh mode. It sits between the per-object draw FSMs and the VGA adapter.

---
 rtl/layer_compositor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// Frame sequencer that enables draw layers one at a time in index order and
// multiplexes the active layer's pixel stream onto one registered write port.
module layer_compositor #(
  parameter int              NUM_LAYERS = 8,
  parameter int              X_W        = 9,
  parameter int              Y_W        = 8,
  parameter int              C_W        = 12,
  parameter logic [C_W-1:0]  KEY_COLOR  = '0,
  parameter int              TIMEOUT    = 131072,
  localparam int             LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      go,
  input  logic                      continuous,
  input  logic [NUM_LAYERS-1:0]     layer_valid_mask,
  input  logic [NUM_LAYERS-1:0]     key_enable_mask,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic [NUM_LAYERS*X_W-1:0] layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0] layer_y,
  input  logic [NUM_LAYERS*C_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]     layer_we,
  output logic [NUM_LAYERS-1:0]     layer_enable,
  output logic [X_W-1:0]            X_out,
  output logic [Y_W-1:0]            Y_out,
  output logic [C_W-1:0]            Color_out,
  output logic                      writeEn,
  output logic [LW-1:0]             current_layer,
  output logic                      busy,
  output logic                      frame_done,
  output logic [NUM_LAYERS-1:0]     timeout_flags
);

  // state     | meaning
  // IDLE      | waiting for go, ptr held at 0
  // SELECT    | test layer ptr; skip costs one cycle
  // DRAW      | layer ptr enabled, watchdog running
  // FRAME_END | one-cycle frame_done, restart or idle
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SELECT    = 2'd1,
    S_DRAW      = 2'd2,
    S_FRAME_END = 2'd3
  } state_t;

  // Watchdog counts down from TIMEOUT-1; reaching zero equals TIMEOUT DRAW cycles.
  localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t                r_state;
  logic [LW-1:0]         r_ptr;
  logic [NUM_LAYERS-1:0] r_enable;
  logic [WD_W-1:0]       r_wdog;
  logic                  r_frame_done;
  logic [NUM_LAYERS-1:0] r_tflags;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [C_W-1:0]        r_color;
  logic                  r_we;

  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;
  logic [C_W-1:0]        w_color;
  logic                  w_we_sel;
  logic                  w_key_sel;
  logic                  w_valid;
  logic                  w_done;
  logic                  w_ptr_last;
  logic                  w_wd_exp;
  logic                  w_key_hit;
  logic                  w_we;
  logic [NUM_LAYERS-1:0] w_onehot;

  always_comb begin
    w_x       = '0;
    w_y       = '0;
    w_color   = '0;
    w_we_sel  = 1'b0;
    w_key_sel = 1'b0;
    w_valid   = 1'b0;
    w_done    = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (r_ptr == LW'(i)) begin
        w_x       = layer_x[i*X_W +: X_W];
        w_y       = layer_y[i*Y_W +: Y_W];
        w_color   = layer_color[i*C_W +: C_W];
        w_we_sel  = layer_we[i];
        w_key_sel = key_enable_mask[i];
        w_valid   = layer_valid_mask[i];
        w_done    = layer_done[i];
      end
    end
  end

  assign w_ptr_last = (r_ptr == LW'(NUM_LAYERS - 1));
  assign w_wd_exp   = (TIMEOUT != 0) && (r_wdog == '0);
  assign w_onehot   = NUM_LAYERS'(1) << r_ptr;
  // Key test looks at the incoming colour so the write decision lines up with the pixel.
  assign w_key_hit  = w_key_sel && (w_color == KEY_COLOR);
  assign w_we       = (r_state == S_DRAW) && w_we_sel && !w_key_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_we    <= 1'b0;
    end else begin
      r_x     <= w_x;
      r_y     <= w_y;
      r_color <= w_color;
      r_we    <= w_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_enable     <= '0;
      r_wdog       <= '0;
      r_frame_done <= 1'b0;
      r_tflags     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ptr <= '0;
          if (go) begin
            r_tflags <= '0;
            r_state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_valid) begin
            r_state  <= S_DRAW;
            r_enable <= w_onehot;
            r_wdog   <= WD_LOAD;
          end else if (w_ptr_last) begin
            r_state      <= S_FRAME_END;
            r_frame_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_DRAW: begin
          if (w_done || w_wd_exp) begin
            r_enable <= '0;
            // A simultaneous done is a normal finish, not a timeout.
            if (!w_done) r_tflags[r_ptr] <= 1'b1;
            if (w_ptr_last) begin
              r_state      <= S_FRAME_END;
              r_frame_done <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= S_SELECT;
            end
          end else if (r_wdog != '0) begin
            r_wdog <= r_wdog - 1'b1;
          end
        end
        S_FRAME_END: begin
          r_ptr <= '0;
          if (continuous) begin
            r_tflags <= '0;
            r_state  <= S_SELECT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign layer_enable  = r_enable;
  assign X_out         = r_x;
  assign Y_out         = r_y;
  assign Color_out     = r_color;
  assign writeEn       = r_we;
  assign current_layer = r_ptr;
  assign busy          = (r_state != S_IDLE);
  assign frame_done    = r_frame_done;
  assign timeout_flags = r_tflags;

endmodule
